// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle ALU ops plus bit-serial shifts (one position per cycle).
// Valid/ready on both sides; flush aborts any in-flight or held operation.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUCode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [SHAMT_W-1:0]   count;
  logic [1:0]           shift_op;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic                 accept;
  logic                 slt, sltu;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH-1:0]     shift_res;

  assign shamt     = B[SHAMT_W-1:0];
  assign is_shift  = (ALUCode == 4'd6) || (ALUCode == 4'd7) || (ALUCode == 4'd8);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign zero      = (result == '0);
  assign accept    = in_valid && in_ready && !flush;
  assign slt       = $signed(A) < $signed(B);
  assign sltu      = A < B;

  // Shift codes only reach this path with shamt==0, where the result is A.
  always_comb begin
    alu_res = '0;
    case (ALUCode)
      4'd0:                 alu_res = A + B;
      4'd1:                 alu_res = A - B;
      4'd3:                 alu_res = A & B;
      4'd4:                 alu_res = A ^ B;
      4'd5:                 alu_res = A | B;
      4'd6, 4'd7, 4'd8:     alu_res = A;
      4'd9:                 alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'd10:                alu_res = {{(WIDTH-1){1'b0}}, sltu};
      default:              alu_res = '0;
    endcase
  end

  always_comb begin
    shift_res = result;
    case (shift_op)
      2'd0:    shift_res = {result[WIDTH-2:0], 1'b0};
      2'd1:    shift_res = {1'b0, result[WIDTH-1:1]};
      default: shift_res = {result[WIDTH-1], result[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
        SHIFT:   if (count == SHAMT_W'(1)) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      count    <= '0;
      shift_op <= 2'd0;
    end else if (flush) begin
      count    <= '0;
    end else if (accept) begin
      if (is_shift && shamt != '0) begin
        result   <= A;
        count    <= shamt;
        shift_op <= (ALUCode == 4'd6) ? 2'd0 : (ALUCode == 4'd7) ? 2'd1 : 2'd2;
      end else begin
        result   <= alu_res;
      end
    end else if (state == SHIFT) begin
      result <= shift_res;
      count  <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALUCode produced by the ID-stage ALU decoder, together with two operands.
- Non-shift operations complete in one cycle.
- Shifts (SLL/SRL/SRA) run iteratively, one bit position per cycle, to save area.
- Sits between ID and MEM/WB, with valid/ready handshakes on both sides and a flush input driven by the hazard/branch logic.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width. Must equal clog2(WIDTH). Shift amount is B[SHAMT_W-1:0].

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  ALUCode, A and B are valid.
- in_ready  output  1  unit can accept an operation.
- ALUCode  input  4  operation code (encoding below).
- A  input  WIDTH  operand 1.
- B  input  WIDTH  operand 2 (register or immediate).
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  high when result == 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- ALUCode encoding:
  - 0 ADD: A+B. 1 SUB: A-B, both mod 2^WIDTH.
  - 3 AND, 4 XOR, 5 OR.
  - 6 SLL, 7 SRL, 8 SRA (arithmetic, sign fill from A[WIDTH-1]).
  - 9 SLT: signed A<B gives 1, else 0, zero-extended. 10 SLTU: same, unsigned.
  - 2 and 11-15 are undefined: result 0, one-cycle path.
- States: IDLE, SHIFT, DONE.
- Reset (asynchronous):
  - state=IDLE, result=0, shift count=0.
  - out_valid=0, busy=0, in_ready=1, zero=1.
- in_ready = (state==IDLE). An operation is accepted on a clock edge with in_valid && in_ready.
- IDLE, on accept:
  - Non-shift code, or shift with shamt==0: result computed and registered; go to DONE. out_valid is high 1 edge after accept.
  - Shift with shamt>0: latch A into result, latch shamt into count and the shift type; go to SHIFT.
- SHIFT:
  - Each edge shifts result by one position (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrements count.
  - The edge where count==1 moves to DONE.
  - out_valid is high shamt+1 edges after accept; shamt=31 gives 32 edges.
  - ALUCode/A/B changes during SHIFT are ignored.
- DONE:
  - out_valid=1; result and zero held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - No same-cycle re-accept: in_ready is low in DONE. Throughput for non-shift ops is therefore 1 op per 2 cycles.
- zero is combinational from the registered result.
  - It is meaningful only when out_valid=1.
  - During SHIFT it tracks the partial result.
- flush:
  - Highest priority over all synchronous events.
  - Any state goes to IDLE; count=0; result keeps its last value; out_valid=0 next cycle.
  - An in_valid asserted in the same cycle as flush is NOT accepted.
- Reset mid-SHIFT or mid-DONE returns immediately to the reset values; no partial result is emitted.
- in_valid without in_ready has no effect. The upstream holds its inputs until accepted.

Test Plan:
- ADD/SUB:
  - ALUCode=0, A=0x7FFFFFFF, B=1 -> one edge later out_valid=1, result=0x80000000, zero=0.
  - ALUCode=1, A=5, B=5 -> result=0, zero=1.
- Compare:
  - ALUCode=9, A=0xFFFFFFFF, B=1 -> result=1.
  - ALUCode=10, same operands -> result=0.
  - ALUCode=12 -> result=0 after 1 edge.
- Shifts:
  - ALUCode=8, A=0x80000000, B=4 -> out_valid exactly 5 edges after accept, result=0xF8000000; busy=1 throughout.
  - ALUCode=6, A=1, B=31 -> 32 edges, result=0x80000000.
  - ALUCode=7, B=0 -> 1 edge, result=A.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> result, zero and out_valid stable, in_ready=0.
  - Raise out_ready -> IDLE and in_ready=1 the next cycle.
- Flush/reset:
  - Assert flush 3 cycles into a 20-bit SRL -> out_valid never rises, IDLE next cycle.
  - Assert flush together with in_valid in IDLE -> no accept.
  - Assert reset asynchronously mid-SHIFT -> out_valid=0, in_ready=1 immediately, without waiting for a clock edge.
- Back-to-back random:
  - 1000 random ops with random out_ready, compared against a golden model.
  - Check latency 1 (non-shift) or shamt+1 (shift), and that no result is lost or duplicated.
